// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared types and sizing helpers for the MLP network sequencer
package mlp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_GAP,
      S_SCAN,
      S_FINISH
   } seq_state_t;

   // Running-best record; fields are sized for the widest supported build and
   // trimmed to the real class/data widths at the outputs.
   localparam int IDX_MAX_W   = 16;
   localparam int SCORE_MAX_W = 32;

   typedef struct packed {
      logic [IDX_MAX_W-1:0]          idx;
      logic signed [SCORE_MAX_W-1:0] score;
      logic                          valid;
   } argmax_t;

   function automatic int vec_depth(input int n, input int vec);
      return (n + vec - 1) / vec;
   endfunction

   function automatic int addr_w(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/mlp_sequencer_if.sv
// rtl/mlp_sequencer_if.sv - layer-engine handshake and final-output BRAM port bundle
interface mlp_sequencer_if #(
   parameter int NUM_LAYERS = 3,
   parameter int DATA_WIDTH = 16,
   parameter int VEC        = 16,
   parameter int OUT_DEPTH  = 10,
   localparam int LIDX_WIDTH     = $clog2(NUM_LAYERS) + 1,
   localparam int OUT_ADDR_WIDTH = mlp_pkg::addr_w(mlp_pkg::vec_depth(OUT_DEPTH, VEC))
);
   logic [NUM_LAYERS-1:0]     layer_start;
   logic [NUM_LAYERS-1:0]     layer_done;
   logic [LIDX_WIDTH-1:0]     layer_idx;
   logic [OUT_ADDR_WIDTH-1:0] out_rdaddr;
   logic [VEC*DATA_WIDTH-1:0] out_q;

   modport master (output layer_start, layer_idx, out_rdaddr, input layer_done, out_q);
   modport slave  (input layer_start, layer_idx, out_rdaddr, output layer_done, out_q);
endinterface

// File: rtl/argmax_vec.sv
// rtl/argmax_vec.sv - combinational signed argmax over one BRAM word with lane mask
module argmax_vec #(
   parameter int VEC        = 16,
   parameter int DATA_WIDTH = 16,
   localparam int LANE_WIDTH = mlp_pkg::addr_w(VEC)
) (
   input  logic [VEC*DATA_WIDTH-1:0]   data,
   input  logic [VEC-1:0]              mask,
   output logic [LANE_WIDTH-1:0]       best_lane,
   output logic signed [DATA_WIDTH-1:0] best_val,
   output logic                        any_valid
);
   logic signed [DATA_WIDTH-1:0] lane;

   // Walk lanes upward; strictly-greater replacement keeps the lowest lane on ties.
   always_comb begin
      best_lane = '0;
      best_val  = '0;
      any_valid = 1'b0;
      lane      = '0;
      for (int l = 0; l < VEC; l++) begin
         lane = data[l*DATA_WIDTH +: DATA_WIDTH];
         if (mask[l] && (!any_valid || lane > best_val)) begin
            best_lane = LANE_WIDTH'(l);
            best_val  = lane;
            any_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mlp_sequencer.sv
// rtl/mlp_sequencer.sv - sequences the layer engines then argmax-scans the final output
module mlp_sequencer
   import mlp_pkg::*;
#(
   parameter int NUM_LAYERS = 3,
   parameter int DATA_WIDTH = 16,
   parameter int VEC        = 16,
   parameter int OUT_DEPTH  = 10,
   parameter int CYC_WIDTH  = 32,
   localparam int OUT_VEC_DEPTH  = vec_depth(OUT_DEPTH, VEC),
   localparam int OUT_ADDR_WIDTH = addr_w(OUT_VEC_DEPTH),
   localparam int CLASS_WIDTH    = addr_w(OUT_DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   output logic                   busy,
   output logic                   done,
   mlp_sequencer_if.master        eng,
   output logic [CLASS_WIDTH-1:0] class_idx,
   output logic [DATA_WIDTH-1:0]  class_score,
   output logic                   class_valid,
   output logic [CYC_WIDTH-1:0]   cycle_count
);
   localparam int LIDX_WIDTH = $clog2(NUM_LAYERS) + 1;
   localparam int LANE_WIDTH = addr_w(VEC);
   localparam int SCAN_WIDTH = addr_w(OUT_VEC_DEPTH + 1);
   localparam logic [LIDX_WIDTH-1:0]     LAST_LAYER = LIDX_WIDTH'(NUM_LAYERS - 1);
   localparam logic [SCAN_WIDTH-1:0]     SCAN_LAST  = SCAN_WIDTH'(OUT_VEC_DEPTH);
   localparam logic [OUT_ADDR_WIDTH-1:0] ADDR_LAST  = OUT_ADDR_WIDTH'(OUT_VEC_DEPTH - 1);

   seq_state_t                 state, state_nx;
   logic [LIDX_WIDTH-1:0]      layer_idx;
   logic [OUT_ADDR_WIDTH-1:0]  rdaddr, word_q;
   logic [SCAN_WIDTH-1:0]      scan_cnt;
   argmax_t                    best, merged;
   logic [VEC-1:0]             lane_mask;
   logic [LANE_WIDTH-1:0]      lane_best;
   logic signed [DATA_WIDTH-1:0]  lane_val;
   logic signed [SCORE_MAX_W-1:0] lane_ext;
   logic                       lane_any;
   logic                       cur_done, accept, reduce_en;

   assign busy           = (state != S_IDLE);
   assign done           = (state == S_FINISH);
   assign accept         = (state == S_IDLE) && (state_nx == S_RUN);
   assign reduce_en      = (state == S_SCAN) && (scan_cnt != '0);
   assign eng.layer_idx  = layer_idx;
   assign eng.out_rdaddr = rdaddr;
   assign lane_ext       = SCORE_MAX_W'(lane_val);

   // Only the active layer drives start, and only its done bit is listened to.
   always_comb begin
      eng.layer_start = '0;
      cur_done        = 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (layer_idx == LIDX_WIDTH'(i)) begin
            eng.layer_start[i] = (state == S_RUN);
            cur_done           = eng.layer_done[i];
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; abort overrides everything outside IDLE.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start && !abort) state_nx = S_RUN;
         S_RUN:    if (cur_done) state_nx = (layer_idx == LAST_LAYER) ? S_SCAN : S_GAP;
         S_GAP:    state_nx = S_RUN;
         S_SCAN:   if (scan_cnt == SCAN_LAST) state_nx = S_FINISH;
         S_FINISH: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
      if (abort && (state != S_IDLE)) state_nx = S_IDLE;
   end

   // Lanes past the last real element of the final layer are never candidates.
   always_comb begin
      lane_mask = '0;
      for (int l = 0; l < VEC; l++)
         lane_mask[l] = (int'(word_q) * VEC + l) < OUT_DEPTH;
   end

   argmax_vec #(.VEC(VEC), .DATA_WIDTH(DATA_WIDTH)) u_argmax (
      .data      (eng.out_q),
      .mask      (lane_mask),
      .best_lane (lane_best),
      .best_val  (lane_val),
      .any_valid (lane_any)
   );

   // Fold the current word's winner into the running best; earlier words win ties.
   always_comb begin
      merged = best;
      if (reduce_en && lane_any && (!best.valid || lane_ext > best.score)) begin
         merged.idx   = IDX_MAX_W'(int'(word_q) * VEC + int'(lane_best));
         merged.score = lane_ext;
         merged.valid = 1'b1;
      end
   end

   // Layer index, scan address/best tracking, result capture and run-cycle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         layer_idx   <= '0;
         rdaddr      <= '0;
         word_q      <= '0;
         scan_cnt    <= '0;
         best        <= '0;
         class_idx   <= '0;
         class_score <= '0;
         class_valid <= 1'b0;
         cycle_count <= '0;
      end else begin
         word_q <= rdaddr;
         if (accept) begin
            layer_idx   <= '0;
            cycle_count <= '0;
            class_valid <= 1'b0;
         end else if (busy && !(&cycle_count)) begin
            cycle_count <= cycle_count + 1'b1;
         end
         if (state == S_GAP) layer_idx <= layer_idx + 1'b1;
         if ((state == S_RUN) && (state_nx == S_SCAN)) begin
            rdaddr   <= '0;
            scan_cnt <= '0;
            best     <= '0;
         end else if (state == S_SCAN) begin
            scan_cnt <= scan_cnt + 1'b1;
            if (rdaddr != ADDR_LAST) rdaddr <= rdaddr + 1'b1;
            best <= merged;
         end
         if ((state == S_SCAN) && (state_nx == S_FINISH)) begin
            class_valid <= 1'b1;
            class_idx   <= merged.idx[CLASS_WIDTH-1:0];
            class_score <= merged.score[DATA_WIDTH-1:0];
         end
      end
   end
endmodule

// File: tb/tb_mlp_sequencer.sv
// tb/tb_mlp_sequencer.sv - scoreboard bench for mlp_sequencer in three configurations
module tb_mlp_sequencer;

   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] score;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start_a, abort_a, start_b, start_c;
   logic busy_a, done_a, valid_a, busy_b, done_b, valid_b, busy_c, done_c, valid_c;
   logic [3:0]  cls_a, cls_c;
   logic [4:0]  cls_b;
   logic [15:0] scr_a, scr_b, scr_c;
   logic [31:0] cyc_a, cyc_b, cyc_c;

   int checks = 0;
   int errors = 0;
   int elems [32];
   logic [255:0] mem_a [2];
   logic [255:0] mem_b [2];
   logic [255:0] mem_c [2];

   int   lq_a [$];
   res_t res_a [$];
   res_t res_b [$];
   res_t res_c [$];
   int   dones_a = 0, dones_b = 0, dones_c = 0;
   int   tally_a = 0, tally_c = 0;

   mlp_sequencer_if #(.NUM_LAYERS(3), .OUT_DEPTH(10)) ifa ();
   mlp_sequencer_if #(.NUM_LAYERS(3), .OUT_DEPTH(20)) ifb ();
   mlp_sequencer_if #(.NUM_LAYERS(1), .OUT_DEPTH(10)) ifc ();

   mlp_sequencer #(.NUM_LAYERS(3), .OUT_DEPTH(10)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .busy(busy_a), .done(done_a),
      .eng(ifa), .class_idx(cls_a), .class_score(scr_a), .class_valid(valid_a), .cycle_count(cyc_a));
   mlp_sequencer #(.NUM_LAYERS(3), .OUT_DEPTH(20)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .busy(busy_b), .done(done_b),
      .eng(ifb), .class_idx(cls_b), .class_score(scr_b), .class_valid(valid_b), .cycle_count(cyc_b));
   mlp_sequencer #(.NUM_LAYERS(1), .OUT_DEPTH(10)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .abort(1'b0), .busy(busy_c), .done(done_c),
      .eng(ifc), .class_idx(cls_c), .class_score(scr_c), .class_valid(valid_c), .cycle_count(cyc_c));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sx(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   // Layer engine models: A finishes 5/7/3 cycles after start, B at once, C after 3.
   localparam int D_A [3] = '{5, 7, 3};
   int cnt_a [3];
   int cnt_c;
   logic [2:0] en_a, extra_a;
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) cnt_a[i] <= ifa.layer_start[i] ? cnt_a[i] + 1 : 0;
      cnt_c <= ifc.layer_start[0] ? cnt_c + 1 : 0;
   end
   always_comb begin
      ifa.layer_done = '0;
      for (int i = 0; i < 3; i++)
         ifa.layer_done[i] = (en_a[i] && ifa.layer_start[i] && (cnt_a[i] == D_A[i] - 1)) || extra_a[i];
   end
   assign ifb.layer_done = ifb.layer_start;
   assign ifc.layer_done[0] = ifc.layer_start[0] && (cnt_c == 2);

   // Final-output BRAMs, one-cycle read latency.
   always_ff @(posedge clk) begin
      ifa.out_q <= mem_a[ifa.out_rdaddr];
      ifb.out_q <= mem_b[ifb.out_rdaddr];
      ifc.out_q <= mem_c[ifc.out_rdaddr];
   end

   // Monitor A: layer start order, gap between engines, results, busy tally.
   logic [2:0] ls_prev_a = '0;
   int   exp_l;
   res_t r_a, r_b, r_c;
   always @(negedge clk) begin
      if (ifa.layer_start != 3'b0 && ls_prev_a == 3'b0) begin
         if (lq_a.size() == 0) check("a_spurious_layer", 32'(ifa.layer_start), 32'd0);
         else begin
            exp_l = lq_a.pop_front();
            check("a_layer_onehot", 32'(ifa.layer_start), 32'd1 << exp_l);
            check("a_layer_idx", 32'(ifa.layer_idx), 32'(exp_l));
         end
      end
      if (ifa.layer_start != 3'b0 && ls_prev_a != 3'b0 && ifa.layer_start != ls_prev_a)
         check("a_no_gap", 32'(ifa.layer_start), 32'd0);
      ls_prev_a = ifa.layer_start;
      if (busy_a) tally_a++;
      if (busy_c) begin
         tally_c++;
         check("c_layer_idx", 32'(ifc.layer_idx), 32'd0);
      end
      if (done_a) begin
         dones_a++;
         if (res_a.size() == 0) check("a_spurious_done", 32'(done_a), 32'd0);
         else begin
            r_a = res_a.pop_front();
            check("a_class_idx", 32'(cls_a), r_a.idx);
            check("a_class_score", sx(scr_a), r_a.score);
            check("a_class_valid", 32'(valid_a), 32'd1);
         end
      end
      if (done_b) begin
         dones_b++;
         if (res_b.size() == 0) check("b_spurious_done", 32'(done_b), 32'd0);
         else begin
            r_b = res_b.pop_front();
            check("b_class_idx", 32'(cls_b), r_b.idx);
            check("b_class_score", sx(scr_b), r_b.score);
         end
      end
      if (done_c) begin
         dones_c++;
         if (res_c.size() == 0) check("c_spurious_done", 32'(done_c), 32'd0);
         else begin
            r_c = res_c.pop_front();
            check("c_class_idx", 32'(cls_c), r_c.idx);
            check("c_class_score", sx(scr_c), r_c.score);
            check("c_class_valid", 32'(valid_c), 32'd1);
         end
      end
   end

   function automatic res_t model(input int n);
      res_t r;
      int bi = 0;
      int bs = elems[0];
      for (int i = 1; i < n; i++)
         if (elems[i] > bs) begin bi = i; bs = elems[i]; end
      r.idx   = 32'(bi);
      r.score = 32'(bs);
      return r;
   endfunction

   function automatic logic [255:0] word_of(input int w);
      logic [255:0] v;
      for (int l = 0; l < 16; l++) v[l*16 +: 16] = 16'(elems[w*16 + l]);
      return v;
   endfunction

   function automatic int dones_of(input int w);
      return (w == 0) ? dones_a : (w == 1) ? dones_b : dones_c;
   endfunction

   task automatic wait_done(input int w, input int target, input string tag);
      int n = 0;
      while (dones_of(w) < target && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 32'(dones_of(w)), 32'(target));
   endtask

   task automatic set_vec1();
      int v [10] = '{1, 4, -2, 9, 0, 3, 9, -8, 2, 1};
      for (int i = 0; i < 32; i++) elems[i] = (i < 10) ? v[i] : 0;
   endtask

   task automatic run_a(input string tag, input int exp_cyc, input bit poke);
      int base = tally_a;
      int target = dones_a + 1;
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      if (poke) begin
         @(negedge clk);
         start_a = 1'b1; extra_a = 3'b100;
         @(negedge clk);
         start_a = 1'b0; extra_a = 3'b000;
      end
      wait_done(0, target, tag);
      repeat (3) @(negedge clk);
      check({tag, "_cyc"}, cyc_a, 32'(tally_a - base));
      if (exp_cyc > 0) check({tag, "_cyc_model"}, 32'(tally_a - base), 32'(exp_cyc));
      check({tag, "_queues"}, 32'(lq_a.size() + res_a.size()), 32'd0);
      check({tag, "_valid_hold"}, 32'(valid_a), 32'd1);
   endtask

   initial begin
      int n;
      int base;
      rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      en_a = 3'b111; extra_a = 3'b000;
      for (int i = 0; i < 32; i++) elems[i] = 0;
      mem_a[0] = '0; mem_a[1] = '0; mem_b[0] = '0; mem_b[1] = '0; mem_c[0] = '0; mem_c[1] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_layer_start", 32'(ifa.layer_start), 32'd0);
      check("rst_valid", 32'(valid_a), 32'd0);
      check("rst_class_idx", 32'(cls_a), 32'd0);
      check("rst_class_score", 32'(scr_a), 32'd0);
      check("rst_cycle_count", cyc_a, 32'd0);
      check("rst_layer_idx", 32'(ifa.layer_idx), 32'd0);
      check("rst_rdaddr", 32'(ifa.out_rdaddr), 32'd0);

      // Reference vector: tie at 9 resolves to element 3.
      set_vec1();
      mem_a[0] = word_of(0);
      lq_a.push_back(0); lq_a.push_back(1); lq_a.push_back(2);
      res_a.push_back('{idx: 32'd3, score: 32'd9});
      run_a("a_t1", 20, 1'b0);

      // Negative valid lanes with large padding that must never win.
      for (int i = 0; i < 16; i++) elems[i] = (i < 10) ? -5 - i : 32767;
      elems[6] = -3; elems[8] = -3;
      mem_a[0] = word_of(0);
      lq_a.push_back(0); lq_a.push_back(1); lq_a.push_back(2);
      res_a.push_back('{idx: 32'd6, score: 32'(-3)});
      run_a("a_t2", 20, 1'b0);

      // Random vectors against the reference model.
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 16; i++) elems[i] = int'($urandom_range(0, 60000)) - 30000;
         mem_a[0] = word_of(0);
         lq_a.push_back(0); lq_a.push_back(1); lq_a.push_back(2);
         res_a.push_back(model(10));
         run_a("a_rand", 20, 1'b0);
      end

      // Abort during L1 on the same cycle as its done.
      en_a = 3'b101;
      lq_a.push_back(0); lq_a.push_back(1);
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      n = 0;
      while (!ifa.layer_start[1] && n < 200) begin @(negedge clk); n++; end
      check("a_l1_started", 32'(ifa.layer_start[1]), 32'd1);
      repeat (3) @(negedge clk);
      abort_a = 1'b1; extra_a = 3'b010;
      @(negedge clk);
      abort_a = 1'b0; extra_a = 3'b000;
      check("abort_busy", 32'(busy_a), 32'd0);
      check("abort_layer_start", 32'(ifa.layer_start), 32'd0);
      check("abort_valid", 32'(valid_a), 32'd0);
      repeat (20) @(negedge clk);
      check("abort_no_l2", 32'(lq_a.size()), 32'd0);
      check("abort_still_idle", 32'(busy_a), 32'd0);
      en_a = 3'b111;

      // Abort and start together in IDLE: start refused.
      start_a = 1'b1; abort_a = 1'b1; @(negedge clk);
      start_a = 1'b0; abort_a = 1'b0; @(negedge clk);
      check("abort_beats_start", 32'(busy_a), 32'd0);

      // Start and a foreign layer_done pulsed during L0 are ignored.
      set_vec1();
      mem_a[0] = word_of(0);
      lq_a.push_back(0); lq_a.push_back(1); lq_a.push_back(2);
      res_a.push_back('{idx: 32'd3, score: 32'd9});
      run_a("a_t5", 20, 1'b1);

      // Two-word final layer: maximum in word 1.
      for (int i = 0; i < 32; i++) elems[i] = (i < 20) ? int'($urandom_range(0, 2000)) - 1000 : 32767;
      elems[17] = 5000;
      mem_b[0] = word_of(0); mem_b[1] = word_of(1);
      res_b.push_back('{idx: 32'd17, score: 32'd5000});
      start_b = 1'b1; @(negedge clk); start_b = 1'b0;
      wait_done(1, 1, "b_t3");
      for (int i = 0; i < 20; i++) elems[i] = int'($urandom_range(0, 60000)) - 30000;
      mem_b[0] = word_of(0); mem_b[1] = word_of(1);
      res_b.push_back(model(20));
      start_b = 1'b1; @(negedge clk); start_b = 1'b0;
      wait_done(1, 2, "b_rand");

      // Single layer: reset in SCAN, then a clean run.
      set_vec1();
      mem_c[0] = word_of(0);
      start_c = 1'b1; @(negedge clk); start_c = 1'b0;
      n = 0;
      while (!ifc.layer_start[0] && n < 200) begin @(negedge clk); n++; end
      check("c_started", 32'(ifc.layer_start[0]), 32'd1);
      n = 0;
      while (ifc.layer_start[0] && n < 200) begin @(negedge clk); n++; end
      check("c_in_scan", 32'(busy_c), 32'd1);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      check("c_rst_busy", 32'(busy_c), 32'd0);
      check("c_rst_done", 32'(done_c), 32'd0);
      check("c_rst_valid", 32'(valid_c), 32'd0);
      check("c_rst_idx", 32'(cls_c), 32'd0);
      check("c_rst_score", 32'(scr_c), 32'd0);
      check("c_rst_cyc", cyc_c, 32'd0);
      check("c_rst_rdaddr", 32'(ifc.out_rdaddr), 32'd0);
      check("c_rst_ls", 32'(ifc.layer_start), 32'd0);
      res_c.push_back('{idx: 32'd3, score: 32'd9});
      base = tally_c;
      start_c = 1'b1; @(negedge clk); start_c = 1'b0;
      wait_done(2, 1, "c_run");
      repeat (3) @(negedge clk);
      check("c_cyc", cyc_c, 32'(tally_c - base));
      check("c_cyc_model", 32'(tally_c - base), 32'd6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
